// File: rtl/board_run_controller_pkg.sv
// Shared types and constants for the board run controller: FSM encoding,
// status LED positions (counted down from the top LED) and a width helper.
package board_run_controller_pkg;

  typedef enum logic [2:0] {
    S_SOFTRST = 3'd0,
    S_IDLE    = 3'd1,
    S_RUN     = 3'd2,
    S_STEP    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam int unsigned LED_HALT_OFS = 1;
  localparam int unsigned LED_RUN_OFS  = 2;
  localparam int unsigned LED_ZERO_OFS = 3;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/board_run_controller_debounce_pulse.sv
// Button conditioner: 2-FF synchroniser, stability counter and rising-edge pulse.
// Raw edge reaches level/pulse after 2 + DEBOUNCE_CYCLES clocks; no flow control.
module debounce_pulse
  import board_run_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic RESET_n,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, sync_q;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter tracks consecutive samples that disagree with the current level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
        pulse_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw;
      sync_q  <= meta_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/board_run_controller.sv
// Board front-end and run controller: run/step/pause/halt via cpu_ce/mem_ce, held soft reset, LEDs.
// Button edge to state change is 2 + DEBOUNCE_CYCLES + 1 clocks; no flow control.
module board_run_controller
  import board_run_controller_pkg::*;
#(
  parameter int unsigned NUM_SW          = 4,
  parameter int unsigned NUM_LED         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CE_DIV          = 2,
  parameter int unsigned RST_HOLD        = 4
) (
  input  logic               clk,
  input  logic               RESET_n,
  input  logic               btn_run,
  input  logic               btn_step,
  input  logic               btn_rst,
  input  logic [NUM_SW-1:0]  sw,
  input  logic               end_program,
  input  logic               is_zero,
  output logic               cpu_ce,
  output logic               mem_ce,
  output logic               cpu_rst,
  output logic [NUM_SW-1:0]  sw_sync,
  output logic               running,
  output logic               halted,
  output logic [NUM_LED-1:0] led
);

  localparam int unsigned DIV_W  = clog2(CE_DIV);
  localparam int unsigned HOLD_W = clog2(RST_HOLD + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam int unsigned LED_HALT = NUM_LED - LED_HALT_OFS;
  localparam int unsigned LED_RUN  = NUM_LED - LED_RUN_OFS;
  localparam int unsigned LED_ZERO = NUM_LED - LED_ZERO_OFS;

  logic run_level, run_pulse, step_level, step_pulse, rst_level, rst_pulse;
  logic run_evt, step_evt, rst_evt;

  debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .RESET_n(RESET_n), .raw(btn_run), .level(run_level), .pulse(run_pulse)
  );
  debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(clk), .RESET_n(RESET_n), .raw(btn_step), .level(step_level), .pulse(step_pulse)
  );
  debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk(clk), .RESET_n(RESET_n), .raw(btn_rst), .level(rst_level), .pulse(rst_pulse)
  );

  assign run_evt  = run_pulse & run_level;
  assign step_evt = step_pulse & step_level;
  assign rst_evt  = rst_pulse & rst_level;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                ce_now;
  logic                mem_ce_q, mem_ce_d;
  logic                cpu_rst_q, running_q, halted_q, is_zero_q;
  logic [NUM_SW-1:0]   sw_meta_q, sw_sync_q;
  logic [NUM_LED-1:0]  led_q, led_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    div_d   = div_q;
    ce_now  = 1'b0;
    unique case (state_q)
      S_SOFTRST: begin
        hold_d = hold_q - 1'b1;
        if (hold_q <= HOLD_ONE) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (end_program)   state_d = S_DONE;
        else if (run_evt)  state_d = S_RUN;
        else if (step_evt) state_d = S_STEP;
      end
      S_RUN: begin
        if (end_program) begin
          state_d = S_DONE;
        end else begin
          // A run press still lets this cycle's due enable through; only later ones stop.
          if (div_q == DIV_LAST) begin
            ce_now = 1'b1;
            div_d  = '0;
          end else begin
            div_d = div_q + 1'b1;
          end
          if (run_evt) state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (end_program) begin
          state_d = S_DONE;
        end else begin
          ce_now  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_SOFTRST;
    endcase

    if (rst_evt) begin
      state_d = S_SOFTRST;
      hold_d  = HOLD_INIT;
      ce_now  = 1'b0;
    end
    if (state_d != S_RUN) div_d = '0;
  end

  assign mem_ce_d = ce_now && (state_d != S_SOFTRST);

  always_comb begin
    led_d               = '0;
    led_d[NUM_SW-1:0]   = sw_sync_q;
    led_d[LED_HALT]     = (state_d == S_DONE);
    led_d[LED_RUN]      = (state_d == S_RUN);
    led_d[LED_ZERO]     = is_zero_q;
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= S_SOFTRST;
      hold_q    <= HOLD_INIT;
      div_q     <= '0;
      mem_ce_q  <= 1'b0;
      cpu_rst_q <= 1'b1;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      is_zero_q <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      div_q     <= div_d;
      mem_ce_q  <= mem_ce_d;
      cpu_rst_q <= (state_d == S_SOFTRST);
      running_q <= (state_d == S_RUN);
      halted_q  <= (state_d == S_DONE);
      is_zero_q <= is_zero;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      led_q     <= led_d;
    end
  end

  assign cpu_ce  = ce_now;
  assign mem_ce  = mem_ce_q;
  assign cpu_rst = cpu_rst_q;
  assign sw_sync = sw_sync_q;
  assign running = running_q;
  assign halted  = halted_q;
  assign led     = led_q;

endmodule
